// File: rtl/rv32_memory_if.sv
// rv32_memory_if: single-port data-memory request/ready bus (master = memory stage, slave = memory)
interface rv32_memory_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  modport master(output req, we, addr, be, wdata, input rdata, ready);
  modport slave(input req, we, addr, be, wdata, output rdata, ready);
endinterface

// File: rtl/rv32_memory.sv
// rv32_memory: RV32 memory stage; dmem master (req/we/addr/be/wdata in, rdata/ready back), stall_o to hazard unit, EX/MEM in, MEM/WB out; optional RV32_MEM_MISALIGN_TRAP_EN traps misaligned accesses
module rv32_memory #(
  parameter int EXC_W      = 8,
  parameter int LD_MIS_BIT = 4,
  parameter int ST_MIS_BIT = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              reg_write_i,
  input  logic              memory_write_i,
  input  logic [1:0]        result_source_i,
  input  logic [EXC_W-1:0]  exceptions_i,
  input  logic [31:0]       instr_i,
  input  logic [31:0]       pc_next_i,
  input  logic [31:0]       alu_result_i,
  input  logic [31:0]       write_data_i,
  rv32_memory_if.master     dmem,
  output logic              stall_o,
  output logic              reg_write_o,
  output logic [1:0]        result_source_o,
  output logic [EXC_W-1:0]  exceptions_o,
  output logic [31:0]       instr_o,
  output logic [31:0]       pc_next_o,
  output logic [31:0]       alu_result_o,
  output logic [31:0]       read_data_o
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t            r_state, w_next;
  logic [2:0]        w_f3;
  logic [1:0]        w_off;
  logic              w_load, w_access, w_mis, w_go, w_req, w_stall;
  logic [3:0]        w_st_be;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ld;
  logic [EXC_W-1:0]  w_mis_exc;
  assign w_f3     = instr_i[14:12];
  assign w_off    = alu_result_i[1:0];
  assign w_load   = result_source_i == 2'b01;
  assign w_access = memory_write_i | w_load;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
  assign w_mis = w_access & ((w_f3[1:0] == 2'b01 & w_off[0]) | (w_f3[1:0] == 2'b10 & w_off != 2'b00));
`else
  assign w_mis = 1'b0;
`endif
  assign w_go      = w_access & ~w_mis;
  assign w_mis_exc = (EXC_W'(w_mis & w_load) << LD_MIS_BIT) | (EXC_W'(w_mis & memory_write_i) << ST_MIS_BIT);
  always_comb begin
    w_next  = r_state;
    w_req   = 1'b0;
    w_stall = 1'b0;
    if (!rst_i) begin
      if (r_state == IDLE) begin
        w_req   = w_go;
        w_stall = w_go & ~dmem.ready;
        w_next  = w_stall ? WAIT : IDLE;
      end else begin
        w_req   = 1'b1;
        w_stall = ~dmem.ready;
        w_next  = dmem.ready ? IDLE : WAIT;
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= IDLE;
    else r_state <= w_next;
  assign w_st_be = w_f3[1:0] == 2'b00 ? 4'b0001 << w_off :
                   w_f3[1:0] == 2'b01 ? (w_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign stall_o    = w_stall;
  assign dmem.req   = w_req;
  assign dmem.we    = w_req & memory_write_i;
  assign dmem.addr  = {alu_result_i[31:2], 2'b00};
  assign dmem.be    = !w_req ? 4'b0000 : memory_write_i ? w_st_be : 4'b1111;
  assign dmem.wdata = w_f3[1:0] == 2'b00 ? {4{write_data_i[7:0]}} :
                      w_f3[1:0] == 2'b01 ? {2{write_data_i[15:0]}} : write_data_i;
  assign w_byte = w_off == 2'd0 ? dmem.rdata[7:0]   : w_off == 2'd1 ? dmem.rdata[15:8] :
                  w_off == 2'd2 ? dmem.rdata[23:16] : dmem.rdata[31:24];
  assign w_half = w_off[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
  assign w_ld   = w_f3 == 3'b000 ? {{24{w_byte[7]}}, w_byte} :
                  w_f3 == 3'b001 ? {{16{w_half[15]}}, w_half} :
                  w_f3 == 3'b010 ? dmem.rdata :
                  w_f3 == 3'b100 ? {24'h0, w_byte} :
                  w_f3 == 3'b101 ? {16'h0, w_half} : 32'h0;
  // A stalled cycle sends a bubble to writeback; the real result lands on the ready edge.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i || w_stall) begin
      reg_write_o     <= 1'b0;
      result_source_o <= 2'b00;
      exceptions_o    <= '0;
      instr_o         <= 32'h0;
      pc_next_o       <= 32'h0;
      alu_result_o    <= 32'h0;
      read_data_o     <= 32'h0;
    end else begin
      reg_write_o     <= reg_write_i & ~w_mis;
      result_source_o <= result_source_i;
      exceptions_o    <= exceptions_i | w_mis_exc;
      instr_o         <= instr_i;
      pc_next_o       <= pc_next_i;
      alu_result_o    <= alu_result_i;
      read_data_o     <= w_load & ~w_mis ? w_ld : 32'h0;
    end
endmodule

// File: tb/tb_rv32_memory.sv
// tb_rv32_memory: table-driven bench for rv32_memory plus wait-state and reset-mid-access sequences
module tb_rv32_memory;
  logic        clk = 1'b0, rst = 1'b1;
  logic        rw, mw;
  logic [1:0]  rs;
  logic [7:0]  exc;
  logic [31:0] instr, pc, alu, wd;
  logic        stall, rw_o;
  logic [1:0]  rs_o;
  logic [7:0]  exc_o;
  logic [31:0] instr_o, pc_o, alu_o, rd_o;
  int n_chk = 0, n_fail = 0;
  rv32_memory_if dmem();
  rv32_memory dut (
    .clk_i(clk), .rst_i(rst), .reg_write_i(rw), .memory_write_i(mw), .result_source_i(rs),
    .exceptions_i(exc), .instr_i(instr), .pc_next_i(pc), .alu_result_i(alu), .write_data_i(wd),
    .dmem(dmem.master), .stall_o(stall), .reg_write_o(rw_o), .result_source_o(rs_o),
    .exceptions_o(exc_o), .instr_o(instr_o), .pc_next_o(pc_o), .alu_result_o(alu_o), .read_data_o(rd_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rw, mw; logic [1:0] rs; logic [2:0] f3; logic [7:0] exc;
    logic [31:0] alu, wd, rdata; logic rdy;
    logic e_req, e_we; logic [31:0] e_addr; logic [3:0] e_be; logic [31:0] e_wd; logic c_wd;
    logic e_stall, e_rw; logic [31:0] e_rd; logic [7:0] e_exc;
  } vec_t;
  vec_t v[13];
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask
  task automatic drive(input logic r, input logic m, input logic [1:0] s, input logic [2:0] f3,
                       input logic [7:0] x, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rdat, input logic rdy, input logic [31:0] p);
    rw = r; mw = m; rs = s; exc = x; alu = a; wd = d; pc = p;
    instr = {17'h0, f3, 12'h003};
    dmem.rdata = rdat; dmem.ready = rdy;
  endtask
  task automatic chk_regs_zero(input string tag);
    chk({tag, " rw_o"}, 32'(rw_o), 32'h0);
    chk({tag, " rs_o"}, 32'(rs_o), 32'h0);
    chk({tag, " exc_o"}, 32'(exc_o), 32'h0);
    chk({tag, " instr_o"}, instr_o, 32'h0);
    chk({tag, " pc_o"}, pc_o, 32'h0);
    chk({tag, " alu_o"}, alu_o, 32'h0);
    chk({tag, " rd_o"}, rd_o, 32'h0);
  endtask
  initial begin
    v[0]  = '{0,1,2'b00,3'b000,8'h00,32'h1003,32'h000000AB,32'h0,1, 1,1,32'h1000,4'b1000,32'hABABABAB,1,0,0,32'h0,8'h00};
    v[1]  = '{1,0,2'b01,3'b000,8'h00,32'h2001,32'h0,32'h0000F500,1, 1,0,32'h2000,4'b1111,32'h0,0,0,1,32'hFFFFFFF5,8'h00};
    v[2]  = '{1,0,2'b01,3'b100,8'h00,32'h2001,32'h0,32'h0000F500,1, 1,0,32'h2000,4'b1111,32'h0,0,0,1,32'h000000F5,8'h00};
    v[3]  = '{1,0,2'b01,3'b101,8'h00,32'h3002,32'h0,32'h80010000,1, 1,0,32'h3000,4'b1111,32'h0,0,0,1,32'h00008001,8'h00};
    v[4]  = '{1,0,2'b00,3'b000,8'h81,32'h12345678,32'h0,32'hFFFFFFFF,1, 0,0,32'h12345678,4'b0000,32'h0,0,0,1,32'h0,8'h81};
    v[5]  = '{0,1,2'b00,3'b001,8'h00,32'h1002,32'h1234BEEF,32'h0,1, 1,1,32'h1000,4'b1100,32'hBEEFBEEF,1,0,0,32'h0,8'h00};
    v[6]  = '{0,1,2'b00,3'b010,8'h00,32'h1004,32'hDEADBEEF,32'h0,1, 1,1,32'h1004,4'b1111,32'hDEADBEEF,1,0,0,32'h0,8'h00};
    v[7]  = '{1,0,2'b01,3'b001,8'h00,32'h2000,32'h0,32'h12348765,1, 1,0,32'h2000,4'b1111,32'h0,0,0,1,32'hFFFF8765,8'h00};
    v[8]  = '{1,0,2'b10,3'b000,8'h00,32'h00000077,32'h0,32'h0,1, 0,0,32'h74,4'b0000,32'h0,0,0,1,32'h0,8'h00};
    v[9]  = '{1,0,2'b01,3'b011,8'h00,32'h2004,32'h0,32'hFFFFFFFF,1, 1,0,32'h2004,4'b1111,32'h0,0,0,1,32'h0,8'h00};
    v[10] = '{0,1,2'b00,3'b000,8'h00,32'h1001,32'h0000005A,32'h0,1, 1,1,32'h1000,4'b0010,32'h5A5A5A5A,1,0,0,32'h0,8'h00};
`ifdef RV32_MEM_MISALIGN_TRAP_EN
    v[11] = '{1,0,2'b01,3'b010,8'h00,32'h4002,32'h0,32'hCAFEF00D,1, 0,0,32'h4000,4'b0000,32'h0,0,0,0,32'h0,8'h10};
`else
    v[11] = '{1,0,2'b01,3'b010,8'h00,32'h4002,32'h0,32'hCAFEF00D,1, 1,0,32'h4000,4'b1111,32'h0,0,0,1,32'hCAFEF00D,8'h00};
`endif
    v[12] = '{1,0,2'b01,3'b000,8'h00,32'h2003,32'h0,32'h7F000000,1, 1,0,32'h2000,4'b1111,32'h0,0,0,1,32'h0000007F,8'h00};
    drive(0, 0, 2'b01, 3'b010, 8'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    #1;
    chk("reset req", 32'(dmem.req), 32'h0);
    chk("reset stall", 32'(stall), 32'h0);
    chk_regs_zero("reset");
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(v[i].rw, v[i].mw, v[i].rs, v[i].f3, v[i].exc, v[i].alu, v[i].wd, v[i].rdata, v[i].rdy, 32'h100 + 32'(i) * 4);
      #1;
      chk($sformatf("v%0d req", i), 32'(dmem.req), 32'(v[i].e_req));
      chk($sformatf("v%0d we", i), 32'(dmem.we), 32'(v[i].e_we));
      chk($sformatf("v%0d addr", i), dmem.addr, v[i].e_addr);
      chk($sformatf("v%0d be", i), 32'(dmem.be), 32'(v[i].e_be));
      if (v[i].c_wd) chk($sformatf("v%0d wdata", i), dmem.wdata, v[i].e_wd);
      chk($sformatf("v%0d stall", i), 32'(stall), 32'(v[i].e_stall));
      @(posedge clk); #1;
      chk($sformatf("v%0d rw_o", i), 32'(rw_o), 32'(v[i].e_rw));
      chk($sformatf("v%0d rd_o", i), rd_o, v[i].e_rd);
      chk($sformatf("v%0d exc_o", i), 32'(exc_o), 32'(v[i].e_exc));
      chk($sformatf("v%0d alu_o", i), alu_o, v[i].alu);
      chk($sformatf("v%0d rs_o", i), 32'(rs_o), 32'(v[i].rs));
      chk($sformatf("v%0d pc_o", i), pc_o, 32'h100 + 32'(i) * 4);
      chk($sformatf("v%0d instr_o", i), instr_o, {17'h0, v[i].f3, 12'h003});
    end
    // LW with two wait cycles
    @(negedge clk);
    drive(1, 0, 2'b01, 3'b010, 8'h0, 32'h5008, 32'h0, 32'h0, 0, 32'h200);
    for (int w = 0; w < 2; w++) begin
      #1;
      chk($sformatf("wait%0d stall", w), 32'(stall), 32'h1);
      chk($sformatf("wait%0d req", w), 32'(dmem.req), 32'h1);
      chk($sformatf("wait%0d addr", w), dmem.addr, 32'h5008);
      chk($sformatf("wait%0d be", w), 32'(dmem.be), 32'hF);
      @(posedge clk); #1;
      chk($sformatf("wait%0d bubble rw_o", w), 32'(rw_o), 32'h0);
      chk($sformatf("wait%0d bubble alu_o", w), alu_o, 32'h0);
      @(negedge clk);
    end
    dmem.rdata = 32'h11223344; dmem.ready = 1'b1;
    #1;
    chk("wait done stall", 32'(stall), 32'h0);
    chk("wait done req", 32'(dmem.req), 32'h1);
    @(posedge clk); #1;
    chk("wait done rd_o", rd_o, 32'h11223344);
    chk("wait done rw_o", 32'(rw_o), 32'h1);
    chk("wait done alu_o", alu_o, 32'h5008);
    // reset in the middle of a wait
    @(negedge clk);
    drive(1, 0, 2'b01, 3'b010, 8'h0, 32'h6000, 32'h0, 32'h0, 0, 32'h300);
    @(posedge clk); #1;
    chk("pre-reset stall", 32'(stall), 32'h1);
    rst = 1'b1;
    #1;
    chk("midwait reset stall", 32'(stall), 32'h0);
    chk("midwait reset req", 32'(dmem.req), 32'h0);
    chk_regs_zero("midwait reset");
    @(negedge clk);
    drive(1, 0, 2'b00, 3'b000, 8'h0, 32'h6000, 32'h0, 32'h0, 0, 32'h304);
    rst = 1'b0;
    #1;
    chk("post-reset idle req", 32'(dmem.req), 32'h0);
    chk("post-reset idle stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    chk("post-reset alu_o", alu_o, 32'h6000);
    chk("post-reset rw_o", 32'(rw_o), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
